// File: rtl/tpg_pattern_sequencer_pkg.sv
// Shared types and constants for the test-pattern sequencer.
package tpg_seq_pkg;

  localparam int unsigned DEF_PATTERN_W = 8;
  localparam int unsigned DEF_DWELL_W   = 8;
  localparam int unsigned DEF_FCNT_W    = 16;

  localparam logic [DEF_PATTERN_W-1:0] PAT_BORDER = 8'd1;
  localparam logic [DEF_PATTERN_W-1:0] PAT_RAMP   = 8'd4;

  typedef enum logic [1:0] {
    SNAP_IDLE   = 2'd0,
    SNAP_ARM    = 2'd1,
    SNAP_ACTIVE = 2'd2,
    SNAP_DONE   = 2'd3
  } snap_state_e;

endpackage

// File: rtl/tpg_pattern_sequencer_if.sv
// Control/status bundle between the host/timing side and the sequencer.
interface tpg_pattern_sequencer_if
  import tpg_seq_pkg::*;
#(
  parameter int unsigned PATTERN_W = DEF_PATTERN_W,
  parameter int unsigned DWELL_W   = DEF_DWELL_W,
  parameter int unsigned FCNT_W    = DEF_FCNT_W
);

  logic                 enable_i;
  logic                 mode_i;
  logic [PATTERN_W-1:0] manual_pattern_i;
  logic [PATTERN_W-1:0] first_pattern_i;
  logic [PATTERN_W-1:0] last_pattern_i;
  logic [DWELL_W-1:0]   dwell_frames_i;
  logic                 vsync_start_i;
  logic                 frame_end_i;
  logic                 snap_req_i;
  logic [PATTERN_W-1:0] pattern_o;
  logic                 pattern_update_o;
  logic [FCNT_W-1:0]    frame_count_o;
  logic                 snap_busy_o;
  logic                 snap_done_o;

  modport master (
    output enable_i, mode_i, manual_pattern_i, first_pattern_i, last_pattern_i,
           dwell_frames_i, vsync_start_i, frame_end_i, snap_req_i,
    input  pattern_o, pattern_update_o, frame_count_o, snap_busy_o, snap_done_o
  );

  modport slave (
    input  enable_i, mode_i, manual_pattern_i, first_pattern_i, last_pattern_i,
           dwell_frames_i, vsync_start_i, frame_end_i, snap_req_i,
    output pattern_o, pattern_update_o, frame_count_o, snap_busy_o, snap_done_o
  );

endinterface

// File: rtl/tpg_pattern_sequencer_snap_fsm.sv
// One-frame snapshot handshake; freeze_c holds the pattern while armed or capturing.
module tpg_snap_fsm
  import tpg_seq_pkg::*;
(
  input  logic clk_i,
  input  logic resetb_i,
  input  logic snap_req_i,
  input  logic vsync_start_i,
  input  logic frame_end_i,
  output logic snap_busy_o,
  output logic snap_done_o,
  output logic freeze_c
);

  snap_state_e state_q;

  // Snapshot state machine with registered busy/done outputs.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= SNAP_IDLE;
      snap_busy_o <= 1'b0;
      snap_done_o <= 1'b0;
    end else begin
      snap_done_o <= 1'b0;
      unique case (state_q)
        SNAP_IDLE: begin
          if (snap_req_i) state_q <= SNAP_ARM;
        end
        SNAP_ARM: begin
          if (vsync_start_i) begin
            state_q     <= SNAP_ACTIVE;
            snap_busy_o <= 1'b1;
          end
        end
        SNAP_ACTIVE: begin
          // A completed frame wins; a vsync without frame_end means the capture is lost.
          if (frame_end_i) begin
            state_q     <= SNAP_DONE;
            snap_busy_o <= 1'b0;
          end else if (vsync_start_i) begin
            state_q     <= SNAP_IDLE;
            snap_busy_o <= 1'b0;
          end
        end
        SNAP_DONE: begin
          snap_done_o <= 1'b1;
          state_q     <= SNAP_IDLE;
        end
        default: begin
          state_q     <= SNAP_IDLE;
          snap_busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Pattern and dwell are held from arming until the captured frame ends.
  assign freeze_c = (state_q == SNAP_ARM) || (state_q == SNAP_ACTIVE);

endmodule

// File: rtl/tpg_pattern_sequencer.sv
// Frame-synchronous pattern-code sequencer (manual / auto-cycle) with snapshot freeze.
module tpg_pattern_sequencer
  import tpg_seq_pkg::*;
#(
  parameter int unsigned          PATTERN_W     = DEF_PATTERN_W,
  parameter int unsigned          DWELL_W       = DEF_DWELL_W,
  parameter int unsigned          FCNT_W        = DEF_FCNT_W,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = PATTERN_W'(PAT_RAMP)
) (
  input logic                   clk_i,
  input logic                   resetb_i,
  tpg_pattern_sequencer_if.slave bus
);

  logic [PATTERN_W-1:0] pattern_q;
  logic [PATTERN_W-1:0] pat_nxt;
  logic [PATTERN_W-1:0] auto_nxt;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   dwell_nxt;
  logic [DWELL_W:0]     dwell_inc;
  logic [DWELL_W:0]     dwell_target;
  logic                 update_q;
  logic [FCNT_W-1:0]    fcnt_q;
  logic                 freeze_c;

  tpg_snap_fsm u_snap_fsm (
    .clk_i         (clk_i),
    .resetb_i      (resetb_i),
    .snap_req_i    (bus.snap_req_i),
    .vsync_start_i (bus.vsync_start_i),
    .frame_end_i   (bus.frame_end_i),
    .snap_busy_o   (bus.snap_busy_o),
    .snap_done_o   (bus.snap_done_o),
    .freeze_c      (freeze_c)
  );

  // Dwell arithmetic carries one extra bit so a lowered dwell setting still expires.
  assign dwell_inc    = {1'b0, dwell_q} + (DWELL_W+1)'(1);
  assign dwell_target = (bus.dwell_frames_i == '0) ? (DWELL_W+1)'(1)
                                                    : {1'b0, bus.dwell_frames_i};

  // Auto-cycle successor: wrap at last, recover to first when out of range or range inverted.
  assign auto_nxt = ((bus.first_pattern_i > bus.last_pattern_i) ||
                     (pattern_q < bus.first_pattern_i) ||
                     (pattern_q >= bus.last_pattern_i)) ? bus.first_pattern_i
                                                        : pattern_q + PATTERN_W'(1);

  // Next pattern and dwell count; updates only take effect on a vsync_start pulse.
  always_comb begin
    pat_nxt   = pattern_q;
    dwell_nxt = dwell_q;
    if (!bus.enable_i) begin
      dwell_nxt = '0;
    end else if (freeze_c) begin
      dwell_nxt = dwell_q;
    end else if (!bus.mode_i) begin
      dwell_nxt = '0;
      if (bus.vsync_start_i) pat_nxt = bus.manual_pattern_i;
    end else if (bus.vsync_start_i) begin
      if (dwell_inc >= dwell_target) begin
        dwell_nxt = '0;
        pat_nxt   = auto_nxt;
      end else begin
        dwell_nxt = dwell_inc[DWELL_W-1:0];
      end
    end
  end

  // Pattern, dwell, update strobe and free-running frame counter registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      pattern_q <= RESET_PATTERN;
      dwell_q   <= '0;
      update_q  <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      pattern_q <= pat_nxt;
      dwell_q   <= dwell_nxt;
      update_q  <= (pat_nxt != pattern_q);
      if (bus.vsync_start_i) fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign bus.pattern_o        = pattern_q;
  assign bus.pattern_update_o = update_q;
  assign bus.frame_count_o    = fcnt_q;

endmodule

// File: tb/tb_tpg_pattern_sequencer.sv
// Directed, table-driven bench for tpg_pattern_sequencer.
module tb_tpg_pattern_sequencer;

  typedef struct {
    logic       en;
    logic       mode;
    logic [7:0] man;
    logic [7:0] first;
    logic [7:0] last;
    logic [7:0] dwell;
    logic [7:0] exp_pat;
    logic       exp_upd;
  } vec_t;

  localparam int NVEC = 23;

  logic clk;
  logic resetb;
  int   n_cmp;
  int   n_err;
  int   fcnt_exp;
  int   done_cnt;
  int   upd_cnt;
  vec_t tbl [NVEC];

  tpg_pattern_sequencer_if bus ();

  tpg_pattern_sequencer dut (
    .clk_i    (clk),
    .resetb_i (resetb),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.snap_done_o === 1'b1) done_cnt++;
    if (bus.pattern_update_o === 1'b1) upd_cnt++;
  end

  function automatic vec_t mk(int en, int mode, int man, int first, int last,
                              int dwell, int pat, int upd);
    vec_t v;
    v.en      = 1'(en);
    v.mode    = 1'(mode);
    v.man     = 8'(man);
    v.first   = 8'(first);
    v.last    = 8'(last);
    v.dwell   = 8'(dwell);
    v.exp_pat = 8'(pat);
    v.exp_upd = 1'(upd);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync();
    bus.vsync_start_i = 1'b1;
    fcnt_exp++;
    tick();
    bus.vsync_start_i = 1'b0;
  endtask

  task automatic pulse_snap();
    bus.snap_req_i = 1'b1;
    tick();
    bus.snap_req_i = 1'b0;
  endtask

  task automatic pulse_frame_end();
    bus.frame_end_i = 1'b1;
    tick();
    bus.frame_end_i = 1'b0;
  endtask

  task automatic set_cfg(input int en, input int mode, input int man, input int first,
                         input int last, input int dwell);
    bus.enable_i         = 1'(en);
    bus.mode_i           = 1'(mode);
    bus.manual_pattern_i = 8'(man);
    bus.first_pattern_i  = 8'(first);
    bus.last_pattern_i   = 8'(last);
    bus.dwell_frames_i   = 8'(dwell);
  endtask

  initial begin
    int u0;
    int d0;
    logic saw_done;
    n_cmp    = 0;
    n_err    = 0;
    fcnt_exp = 0;
    done_cnt = 0;
    upd_cnt  = 0;
    resetb   = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    bus.vsync_start_i = 1'b0;
    bus.frame_end_i   = 1'b0;
    bus.snap_req_i    = 1'b0;

    // Auto-cycle, enable and manual-mode vectors; each row is one frame.
    tbl[0]  = mk(1, 1, 0, 1, 3, 2, 1, 0);
    tbl[1]  = mk(1, 1, 0, 1, 3, 2, 2, 1);
    tbl[2]  = mk(1, 1, 0, 1, 3, 2, 2, 0);
    tbl[3]  = mk(1, 1, 0, 1, 3, 2, 3, 1);
    tbl[4]  = mk(1, 1, 0, 1, 3, 2, 3, 0);
    tbl[5]  = mk(1, 1, 0, 1, 3, 2, 1, 1);
    tbl[6]  = mk(1, 1, 0, 1, 3, 0, 2, 1);
    tbl[7]  = mk(1, 1, 0, 1, 3, 0, 3, 1);
    tbl[8]  = mk(1, 1, 0, 1, 3, 0, 1, 1);
    tbl[9]  = mk(1, 1, 0, 5, 2, 0, 5, 1);
    tbl[10] = mk(1, 1, 0, 5, 2, 0, 5, 0);
    tbl[11] = mk(1, 1, 0, 1, 3, 1, 1, 1);
    tbl[12] = mk(0, 1, 0, 1, 3, 1, 1, 0);
    tbl[13] = mk(1, 1, 0, 1, 3, 2, 1, 0);
    tbl[14] = mk(0, 1, 0, 1, 3, 2, 1, 0);
    tbl[15] = mk(1, 1, 0, 1, 3, 2, 1, 0);
    tbl[16] = mk(1, 1, 0, 1, 3, 2, 2, 1);
    tbl[17] = mk(0, 0, 7, 1, 3, 2, 2, 0);
    tbl[18] = mk(1, 0, 7, 1, 3, 2, 7, 1);
    tbl[19] = mk(1, 0, 7, 1, 3, 2, 7, 0);
    tbl[20] = mk(1, 1, 0, 6, 9, 2, 7, 0);
    tbl[21] = mk(1, 1, 0, 6, 9, 2, 8, 1);
    tbl[22] = mk(1, 1, 0, 8, 8, 1, 8, 0);

    // Reset values.
    ticks(3);
    check("rst_pattern", 32'(bus.pattern_o), 4);
    check("rst_update", 32'(bus.pattern_update_o), 0);
    check("rst_fcnt", 32'(bus.frame_count_o), 0);
    check("rst_busy", 32'(bus.snap_busy_o), 0);
    check("rst_done", 32'(bus.snap_done_o), 0);
    resetb = 1'b1;
    ticks(2);

    // Manual mode, three frames of code 1.
    set_cfg(1, 0, 1, 0, 0, 0);
    u0 = upd_cnt;
    ticks(4);
    check("man_pre_vsync", 32'(bus.pattern_o), 4);
    vsync();
    check("man_f1_pattern", 32'(bus.pattern_o), 1);
    check("man_f1_update", 32'(bus.pattern_update_o), 1);
    for (int f = 0; f < 2; f++) begin
      ticks(4);
      vsync();
      check("man_fn_pattern", 32'(bus.pattern_o), 1);
    end
    tick();
    check("man_update_count", 32'(upd_cnt - u0), 1);
    check("man_fcnt", 32'(bus.frame_count_o), 32'(fcnt_exp));

    // Table-driven frames.
    for (int i = 0; i < NVEC; i++) begin
      set_cfg(int'(tbl[i].en), int'(tbl[i].mode), int'(tbl[i].man), int'(tbl[i].first),
              int'(tbl[i].last), int'(tbl[i].dwell));
      ticks(3);
      check($sformatf("v%0d_pre_update", i), 32'(bus.pattern_update_o), 0);
      vsync();
      check($sformatf("v%0d_pattern", i), 32'(bus.pattern_o), 32'(tbl[i].exp_pat));
      check($sformatf("v%0d_update", i), 32'(bus.pattern_update_o), 32'(tbl[i].exp_upd));
      check($sformatf("v%0d_fcnt", i), 32'(bus.frame_count_o), 32'(fcnt_exp));
      tick();
      check($sformatf("v%0d_update_drop", i), 32'(bus.pattern_update_o), 0);
    end

    // Snapshot: request 10 cycles ahead of vsync, capture, done.
    set_cfg(1, 1, 0, 1, 3, 1);
    ticks(2);
    vsync();
    check("snap_start_pattern", 32'(bus.pattern_o), 1);
    pulse_snap();
    ticks(9);
    check("snap_arm_busy", 32'(bus.snap_busy_o), 0);
    vsync();
    check("snap_busy_rise", 32'(bus.snap_busy_o), 1);
    check("snap_frozen_pattern", 32'(bus.pattern_o), 1);
    check("snap_frozen_update", 32'(bus.pattern_update_o), 0);
    ticks(4);
    check("snap_busy_hold", 32'(bus.snap_busy_o), 1);
    pulse_frame_end();
    check("snap_busy_fall", 32'(bus.snap_busy_o), 0);
    check("snap_done_not_yet", 32'(bus.snap_done_o), 0);
    tick();
    check("snap_done_pulse", 32'(bus.snap_done_o), 1);
    tick();
    check("snap_done_drop", 32'(bus.snap_done_o), 0);
    ticks(2);
    vsync();
    check("snap_resume_pattern", 32'(bus.pattern_o), 2);
    check("snap_resume_update", 32'(bus.pattern_update_o), 1);

    // Request coincident with vsync; capture starts at the next vsync, then aborts.
    ticks(2);
    bus.snap_req_i    = 1'b1;
    bus.vsync_start_i = 1'b1;
    fcnt_exp++;
    tick();
    bus.snap_req_i    = 1'b0;
    bus.vsync_start_i = 1'b0;
    check("coinc_pattern", 32'(bus.pattern_o), 3);
    check("coinc_busy", 32'(bus.snap_busy_o), 0);
    ticks(5);
    check("coinc_arm_busy", 32'(bus.snap_busy_o), 0);
    vsync();
    check("coinc_busy_rise", 32'(bus.snap_busy_o), 1);
    check("coinc_frozen_pattern", 32'(bus.pattern_o), 3);
    ticks(2);
    pulse_snap();
    ticks(3);
    d0 = done_cnt;
    vsync();
    check("abort_busy", 32'(bus.snap_busy_o), 0);
    check("abort_pattern", 32'(bus.pattern_o), 3);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.snap_done_o !== 1'b0) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 0);
    check("abort_done_count", 32'(done_cnt - d0), 0);
    vsync();
    check("post_abort_pattern", 32'(bus.pattern_o), 1);
    check("post_abort_busy", 32'(bus.snap_busy_o), 0);
    check("total_done_count", 32'(done_cnt), 1);

    // Asynchronous reset in the middle of a capture.
    ticks(2);
    vsync();
    check("prerst_pattern", 32'(bus.pattern_o), 2);
    pulse_snap();
    tick();
    vsync();
    check("prerst_busy", 32'(bus.snap_busy_o), 1);
    ticks(2);
    #3;
    resetb = 1'b0;
    #1;
    check("arst_pattern", 32'(bus.pattern_o), 4);
    check("arst_busy", 32'(bus.snap_busy_o), 0);
    check("arst_fcnt", 32'(bus.frame_count_o), 0);
    check("arst_done", 32'(bus.snap_done_o), 0);
    fcnt_exp = 0;
    ticks(3);
    resetb = 1'b1;
    d0 = done_cnt;
    ticks(3);
    vsync();
    check("post_rst_pattern", 32'(bus.pattern_o), 1);
    check("post_rst_update", 32'(bus.pattern_update_o), 1);
    check("post_rst_fcnt", 32'(bus.frame_count_o), 32'(fcnt_exp));
    check("post_rst_busy", 32'(bus.snap_busy_o), 0);
    ticks(3);
    check("post_rst_no_done", 32'(done_cnt - d0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
